// File: rtl/nios_128k_extended_cpu_cpu_debug_ocimem_pkg.sv
// Shared definitions for the OCI debug-memory controller: FSM state
// encoding, bit positions of the fields carried in the JDO command word,
// and the data width of the OCI memory.
package nios_128k_extended_cpu_cpu_debug_ocimem_pkg;

  localparam int DATA_W       = 32;

  // Field positions inside jdo[37:0]
  localparam int JDO_RD       = 34;  // address load also starts a read
  localparam int JDO_CLRERR   = 35;  // address load also clears monitor_error
  localparam int JDO_DATA_LSB = 3;   // write data is jdo[34:3]
  localparam int JDO_ADDR_LSB = 2;   // word address is jdo[ADDR_W+1:2]

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_REQ  = 2'd1,
    RD_WAIT = 2'd2,
    WR_REQ  = 2'd3
  } ocimem_state_e;

endpackage

// File: rtl/nios_128k_extended_cpu_cpu_debug_ocimem_wdog.sv
// Request watchdog for the OCI memory controller.
// Counts every cycle in which 'en' is high and raises 'expire' combinationally
// during the TIMEOUT_CYC-th such cycle, so the owner can abort on that edge.
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   clr         - clear the count (controller is idle)
//   en          - count this cycle (a request is outstanding)
//   expire      - this is the last permitted cycle of the request
// TIMEOUT_CYC must be at least 2.
module nios_128k_extended_cpu_cpu_debug_ocimem_wdog
  import nios_128k_extended_cpu_cpu_debug_ocimem_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  logic [CNT_W-1:0] count;

  assign expire = en && (count == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en && !expire) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/nios_128k_extended_cpu_cpu_debug_ocimem_ctrl.sv
// OCI debug-memory controller. Decodes the synchronized JTAG command word
// and action strobes from the debug slave, runs single-word reads/writes on
// an Avalon-style master port, and returns MonDReg / monitor_ready /
// monitor_error for shift-out.
// Ports:
//   clk, reset                      - system clock, synchronous active-high reset
//   jdo[37:0]                       - command/data word, stable while a strobe is high
//   take_action_ocimem_a            - address load (optional read / error clear)
//   take_action_ocimem_b            - write data and start a write
//   take_no_action_ocimem_a         - read at the current address
//   mem_address/read/write/writedata- Avalon master request side
//   mem_waitrequest/readdata/readdatavalid - Avalon master response side
//   MonDReg, MonAReg                - monitor data and address registers
//   monitor_ready, monitor_error    - idle/complete flag, sticky error flag
// Build option: define NIOS_128K_EXTENDED_OCIMEM_AUTOINC_EN to advance
// MonAReg after every completed (not timed-out) read or write.
module nios_128k_extended_cpu_cpu_debug_ocimem_ctrl
  import nios_128k_extended_cpu_cpu_debug_ocimem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  input  logic              mem_waitrequest,
  input  logic [31:0]       mem_readdata,
  input  logic              mem_readdatavalid,
  output logic [31:0]       MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  ocimem_state_e state, state_next;

  logic any_strobe;
  logic expire;
  logic load_addr;
  logic load_wdata;
  logic cap_rdata;
  logic set_err;
  logic clr_err;

  // jdo carries more than this block decodes (upper flag bits, byte offset)
  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:36], jdo[1:0]};

  assign any_strobe  = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign mem_read    = (state == RD_REQ);
  assign mem_write   = (state == WR_REQ);
  assign mem_address = MonAReg;

  nios_128k_extended_cpu_cpu_debug_ocimem_wdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .clr    (state == IDLE),
    .en     (state != IDLE),
    .expire (expire)
  );

  always_comb begin
    state_next = state;
    load_addr  = 1'b0;
    load_wdata = 1'b0;
    cap_rdata  = 1'b0;
    set_err    = 1'b0;
    clr_err    = 1'b0;
    case (state)
      IDLE: begin
        // Priority a > b > no_action_a; every losing strobe is an error.
        if (take_action_ocimem_a) begin
          load_addr = 1'b1;
          clr_err   = jdo[JDO_CLRERR];
          set_err   = take_action_ocimem_b | take_no_action_ocimem_a;
          if (jdo[JDO_RD]) state_next = RD_REQ;
        end else if (take_action_ocimem_b) begin
          load_wdata = 1'b1;
          set_err    = take_no_action_ocimem_a;
          state_next = WR_REQ;
        end else if (take_no_action_ocimem_a) begin
          state_next = RD_REQ;
        end
      end
      RD_REQ: begin
        set_err = any_strobe | expire;
        if (expire)                state_next = IDLE;
        else if (!mem_waitrequest) state_next = RD_WAIT;
      end
      RD_WAIT: begin
        // Timeout wins over data arriving in the same cycle.
        set_err = any_strobe | expire;
        if (expire) begin
          state_next = IDLE;
        end else if (mem_readdatavalid) begin
          cap_rdata  = 1'b1;
          state_next = IDLE;
        end
      end
      WR_REQ: begin
        set_err = any_strobe | expire;
        if (expire || !mem_waitrequest) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef NIOS_128K_EXTENDED_OCIMEM_AUTOINC_EN
  logic op_done;
  assign op_done = !expire &&
                   (((state == RD_WAIT) && mem_readdatavalid) ||
                    ((state == WR_REQ)  && !mem_waitrequest));
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      MonDReg       <= '0;
      MonAReg       <= '0;
      mem_writedata <= '0;
      monitor_ready <= 1'b1;
      monitor_error <= 1'b0;
    end else begin
      if (load_addr) begin
        MonAReg <= jdo[ADDR_W+JDO_ADDR_LSB-1:JDO_ADDR_LSB];
      end
`ifdef NIOS_128K_EXTENDED_OCIMEM_AUTOINC_EN
      else if (op_done) begin
        MonAReg <= MonAReg + ADDR_W'(1);
      end
`endif

      if (load_wdata) begin
        MonDReg       <= jdo[JDO_DATA_LSB+DATA_W-1:JDO_DATA_LSB];
        mem_writedata <= jdo[JDO_DATA_LSB+DATA_W-1:JDO_DATA_LSB];
      end else if (cap_rdata) begin
        MonDReg <= mem_readdata;
      end

      // Ready only after a full idle cycle with no new command, which
      // also drops it the cycle after any accepted strobe.
      monitor_ready <= (state == IDLE) && !any_strobe;

      // A new error in the same cycle as a clear request stays set.
      if (set_err)      monitor_error <= 1'b1;
      else if (clr_err) monitor_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nios_128k_extended_cpu_cpu_debug_ocimem_ctrl.sv
// Directed bench for the OCI debug-memory controller (ADDR_W=8,
// TIMEOUT_CYC=8). Expectations track NIOS_128K_EXTENDED_OCIMEM_AUTOINC_EN.
module tb_nios_128k_extended_cpu_cpu_debug_ocimem_ctrl;

`ifdef NIOS_128K_EXTENDED_OCIMEM_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic        take_no_action_ocimem_a;
  logic [7:0]  mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;
  logic        mem_readdatavalid;
  logic [31:0] MonDReg;
  logic [7:0]  MonAReg;
  logic        monitor_ready;
  logic        monitor_error;

  int errors = 0;
  int checks = 0;

  nios_128k_extended_cpu_cpu_debug_ocimem_ctrl #(
    .ADDR_W      (8),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .mem_address             (mem_address),
    .mem_read                (mem_read),
    .mem_write               (mem_write),
    .mem_writedata           (mem_writedata),
    .mem_waitrequest         (mem_waitrequest),
    .mem_readdata            (mem_readdata),
    .mem_readdatavalid       (mem_readdatavalid),
    .MonDReg                 (MonDReg),
    .MonAReg                 (MonAReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [37:0] mk_addr(input logic [7:0] addr, input logic rd, input logic clr);
    logic [37:0] j;
    j       = '0;
    j[9:2]  = addr;
    j[34]   = rd;
    j[35]   = clr;
    return j;
  endfunction

  function automatic logic [37:0] mk_data(input logic [31:0] d);
    logic [37:0] j;
    j       = '0;
    j[34:3] = d;
    return j;
  endfunction

  initial begin
    reset                   = 1'b1;
    jdo                     = '0;
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    mem_waitrequest         = 1'b0;
    mem_readdata            = '0;
    mem_readdatavalid       = 1'b0;
    tick();
    tick();

    // Reset values
    chk("rst_mondreg", MonDReg, 32'h0);
    chk("rst_monareg", 32'(MonAReg), 32'h0);
    chk("rst_read", 32'(mem_read), 32'd0);
    chk("rst_write", 32'(mem_write), 32'd0);
    chk("rst_wdata", mem_writedata, 32'h0);
    chk("rst_ready", 32'(monitor_ready), 32'd1);
    chk("rst_error", 32'(monitor_error), 32'd0);
    reset = 1'b0;
    tick();

    // Address load with read at 0x10, data returned two cycles later
    jdo = mk_addr(8'h10, 1'b1, 1'b0);
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    chk("rd1_read_hi", 32'(mem_read), 32'd1);
    chk("rd1_addr", 32'(mem_address), 32'h10);
    chk("rd1_ready_lo", 32'(monitor_ready), 32'd0);
    tick();
    chk("rd1_read_lo", 32'(mem_read), 32'd0);
    tick();
    mem_readdata      = 32'hDEADBEEF;
    mem_readdatavalid = 1'b1;
    tick();
    mem_readdatavalid = 1'b0;
    chk("rd1_mondreg", MonDReg, 32'hDEADBEEF);
    tick();
    chk("rd1_ready", 32'(monitor_ready), 32'd1);
    chk("rd1_monareg", 32'(MonAReg), AUTOINC ? 32'h11 : 32'h10);
    chk("rd1_error", 32'(monitor_error), 32'd0);

    // Write 0x12345678 with waitrequest high for three cycles
    jdo = mk_data(32'h12345678);
    take_action_ocimem_b = 1'b1;
    mem_waitrequest      = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    chk("wr_mondreg", MonDReg, 32'h12345678);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wr_write_hi%0d", i), 32'(mem_write), 32'd1);
      chk($sformatf("wr_wdata%0d", i), mem_writedata, 32'h12345678);
      if (i == 3) mem_waitrequest = 1'b0;
      tick();
    end
    chk("wr_write_lo", 32'(mem_write), 32'd0);
    chk("wr_error", 32'(monitor_error), 32'd0);
    tick();
    chk("wr_ready", 32'(monitor_ready), 32'd1);
    chk("wr_monareg", 32'(MonAReg), AUTOINC ? 32'h12 : 32'h10);

    // Load 0xFF without read, then read-next; wraps with auto-increment
    jdo = mk_addr(8'hFF, 1'b0, 1'b0);
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    chk("ff_monareg", 32'(MonAReg), 32'hFF);
    chk("ff_no_read", 32'(mem_read), 32'd0);
    tick();
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
    chk("ff_read_hi", 32'(mem_read), 32'd1);
    chk("ff_addr", 32'(mem_address), 32'hFF);
    tick();
    mem_readdata      = 32'hCAFEF00D;
    mem_readdatavalid = 1'b1;
    tick();
    mem_readdatavalid = 1'b0;
    chk("ff_mondreg", MonDReg, 32'hCAFEF00D);
    chk("ff_wrap", 32'(MonAReg), AUTOINC ? 32'h00 : 32'hFF);
    tick();

    // Strobe during RD_WAIT is dropped and flagged
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
    tick();
    jdo = mk_data(32'h00000055);
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    chk("ovr_error", 32'(monitor_error), 32'd1);
    chk("ovr_no_write", 32'(mem_write), 32'd0);
    chk("ovr_mondreg", MonDReg, 32'hCAFEF00D);
    mem_readdata      = 32'h0BADF00D;
    mem_readdatavalid = 1'b1;
    tick();
    mem_readdatavalid = 1'b0;
    chk("ovr_rd_data", MonDReg, 32'h0BADF00D);
    chk("ovr_wdata_kept", mem_writedata, 32'h12345678);
    tick();
    jdo = mk_addr(8'h20, 1'b0, 1'b1);
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    chk("clr_error", 32'(monitor_error), 32'd0);
    chk("clr_monareg", 32'(MonAReg), 32'h20);
    tick();

    // Simultaneous a and b: a wins, b is flagged
    jdo = mk_addr(8'h30, 1'b0, 1'b0);
    take_action_ocimem_a = 1'b1;
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    chk("prio_monareg", 32'(MonAReg), 32'h30);
    chk("prio_error", 32'(monitor_error), 32'd1);
    chk("prio_no_write", 32'(mem_write), 32'd0);
    tick();
    jdo = mk_addr(8'h40, 1'b0, 1'b1);
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    chk("prio_clr", 32'(monitor_error), 32'd0);
    tick();

    // waitrequest stuck high: abort after 8 cycles
    mem_waitrequest = 1'b1;
    jdo = mk_addr(8'h40, 1'b1, 1'b0);
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("to_read_hi%0d", i), 32'(mem_read), 32'd1);
      tick();
    end
    chk("to_read_lo", 32'(mem_read), 32'd0);
    chk("to_error", 32'(monitor_error), 32'd1);
    mem_waitrequest   = 1'b0;
    mem_readdata      = 32'hAAAA5555;
    mem_readdatavalid = 1'b1;
    tick();
    mem_readdatavalid = 1'b0;
    chk("to_late_data", MonDReg, 32'h0BADF00D);
    chk("to_monareg", 32'(MonAReg), 32'h40);
    chk("to_read_idle", 32'(mem_read), 32'd0);
    tick();
    chk("to_ready", 32'(monitor_ready), 32'd1);

    // Reset in the middle of a write
    jdo = mk_data(32'h00009999);
    take_action_ocimem_b = 1'b1;
    mem_waitrequest      = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    chk("rw_write_hi", 32'(mem_write), 32'd1);
    reset = 1'b1;
    tick();
    chk("rw_write_lo", 32'(mem_write), 32'd0);
    chk("rw_read_lo", 32'(mem_read), 32'd0);
    chk("rw_mondreg", MonDReg, 32'h0);
    chk("rw_monareg", 32'(MonAReg), 32'h0);
    chk("rw_wdata", mem_writedata, 32'h0);
    chk("rw_ready", 32'(monitor_ready), 32'd1);
    chk("rw_error", 32'(monitor_error), 32'd0);
    reset           = 1'b0;
    mem_waitrequest = 1'b0;
    tick();
    chk("rw_idle_write", 32'(mem_write), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
